// File: rtl/example_stim_checker.sv
// example_stim_checker: on-chip golden harness for the three-input example datapath.
// Issues N_VECTORS pseudo-random (s1, s2, r) vectors from an 8-bit LFSR, models the
// datapath response o = s1 delayed 2 ^ s2 delayed 1 ^ r delayed 1 (delays counted from
// LFSR sampling), compares it against o_i and reports a saturating mismatch count, the
// index of the first mismatch and a pass flag.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      start a run (sampled in IDLE only)
//   busy_o       high in RUN and FLUSH
//   done_o       one-cycle pulse when the run finishes
//   pass_o       no mismatches in the last run; held until next start
//   s1_o/s2_o/r_o registered stimulus to the datapath
//   o_i          datapath output
//   err_cnt_o    saturating mismatch count
//   first_err_o  index of the first mismatching vector (valid if err_cnt_o != 0)
module example_stim_checker #(
    parameter int unsigned       N_VECTORS = 256,
    parameter int unsigned       CNT_W     = 16,
    parameter int unsigned       LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] SEED      = 8'hA5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             s1_o,
    output logic             s2_o,
    output logic             r_o,
    input  logic             o_i,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] first_err_o
);

    // The issue counter must reach N_VECTORS-1 even when CNT_W is narrow; the reported
    // index is its low CNT_W bits.
    localparam int unsigned NW   = $clog2(N_VECTORS + 1);
    localparam int unsigned IdxW = (CNT_W > NW) ? CNT_W : NW;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_VECTORS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e            state_q, state_d;
    logic              flush_q, flush_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [IdxW-1:0]   vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  first_err_q, first_err_d;
    logic              pass_q, pass_d;
    logic              s1_q, s1_d, s2_q, s2_d, r_q, r_d;
    // Shadow pipeline: stage 1 marks a cycle with a freshly issued vector, stage 2 the
    // cycle in which that vector's response is checked.
    logic              v1_q, v1_d, v2_q, v2_d;
    logic [IdxW-1:0]   idx1_q, idx1_d, idx2_q, idx2_d;
    logic              s1d_q, s1d_d;
    logic              exp_o;

    // Fibonacci form of x^8+x^6+x^5+x^4+1.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // s2/r of the following vector are on the outputs while vector k is checked.
    assign exp_o = s1d_q ^ s2_q ^ r_q;

    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        lfsr_d      = lfsr_q;
        vec_idx_d   = vec_idx_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        s1_d        = 1'b0;
        s2_d        = 1'b0;
        r_d         = 1'b0;
        v1_d        = 1'b0;
        idx1_d      = idx1_q;
        v2_d        = v1_q;
        idx2_d      = idx1_q;
        s1d_d       = s1_q;

        if (v2_q && (o_i != exp_o)) begin
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (err_cnt_q == '0) begin
                first_err_d = idx2_q[CNT_W-1:0];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    lfsr_d      = SEED;
                    vec_idx_d   = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                s1_d      = lfsr_q[0];
                s2_d      = lfsr_q[1];
                r_d       = lfsr_q[2];
                v1_d      = 1'b1;
                idx1_d    = vec_idx_q;
                lfsr_d    = lfsr_step(lfsr_q);
                vec_idx_d = vec_idx_q + IdxW'(1);
                if (vec_idx_q == LastIdx) begin
                    state_d = StFlush;
                    flush_d = 1'b0;
                end
            end
            StFlush: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                pass_d  = (err_cnt_q == '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_q     <= 1'b0;
            lfsr_q      <= '0;
            vec_idx_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            r_q         <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            idx1_q      <= '0;
            idx2_q      <= '0;
            s1d_q       <= 1'b0;
        end else begin
            flush_q     <= flush_d;
            lfsr_q      <= lfsr_d;
            vec_idx_q   <= vec_idx_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            r_q         <= r_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            idx1_q      <= idx1_d;
            idx2_q      <= idx2_d;
            s1d_q       <= s1d_d;
        end
    end

    assign busy_o      = (state_q == StRun) || (state_q == StFlush);
    assign done_o      = (state_q == StDone);
    assign pass_o      = pass_q;
    assign s1_o        = s1_q;
    assign s2_o        = s2_q;
    assign r_o         = r_q;
    assign err_cnt_o   = err_cnt_q;
    assign first_err_o = first_err_q;

endmodule

// File: tb/tb_example_stim_checker.sv
// Bench for example_stim_checker: a loopback datapath model feeds o_i (optionally
// corrupted), a cycle-indexed reference model predicts every output, and one compare
// process checks all outputs on every cycle out of reset. Two narrow instances cover
// single-vector runs and counter saturation.
module tb_example_stim_checker;

    localparam int N = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // ---------------- main instance ----------------
    logic        start = 1'b0;
    logic        busy, done, pass, s1, s2, r, o_in;
    logic [15:0] err, first;

    example_stim_checker u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .s1_o       (s1),
        .s2_o       (s2),
        .r_o        (r),
        .o_i        (o_in),
        .err_cnt_o  (err),
        .first_err_o(first)
    );

    // Behavioural datapath: o = s1 delayed 1 more register ^ s2 ^ r.
    logic dp_d1 = 1'b0;
    always @(posedge clk) dp_d1 <= s1;

    // mode 0: clean, 1: always inverted, 2: single flip at vector 17
    int   mode = 0;
    int   cyc = -1;  // cycles since start was sampled, -1 when not in a run
    logic inj;
    assign inj  = (mode == 1) || (mode == 2 && cyc == 17 + 2);
    assign o_in = dp_d1 ^ s2 ^ r ^ inj;

    // Reference stimulus sequence from the polynomial x^8+x^6+x^5+x^4+1.
    logic [2:0] vec[N];  // {r, s2, s1}
    initial begin
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < N; i++) begin
            vec[i] = l[2:0];
            l = {l[6:0], ^(l & 8'b1011_1000)};
        end
    end

    // Reference model: vector k is on the outputs in cycle k+1, its response is
    // presented in cycle k+2 and counted from cycle k+3; done in cycle N+2.
    int exp_err = 0;
    int exp_first = 0;
    logic exp_pass = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc       <= -1;
            exp_err   <= 0;
            exp_first <= 0;
            exp_pass  <= 1'b0;
        end else if (cyc < 0) begin
            if (start) begin
                cyc       <= 0;
                exp_err   <= 0;
                exp_first <= 0;
                exp_pass  <= 1'b0;
            end
        end else begin
            if (cyc >= 2 && cyc - 2 < N && inj) begin
                if (exp_err < 65535) exp_err <= exp_err + 1;
                if (exp_err == 0) exp_first <= cyc - 2;
            end
            if (cyc == N + 2) begin
                exp_pass <= (exp_err == 0);
                cyc      <= -1;
            end else begin
                cyc <= cyc + 1;
            end
        end
    end

    int done_seen = 0;
    initial begin
        logic [2:0]  es;
        logic [37:0] got, expv;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                es   = (cyc >= 1 && cyc <= N) ? vec[cyc-1] : 3'b000;
                got  = {busy, done, pass, r, s2, s1, err, first};
                expv = {(cyc >= 0 && cyc <= N + 1), (cyc == N + 2), exp_pass, es,
                        16'(exp_err), 16'(exp_first)};
                total++;
                if (got !== expv) begin
                    bad++;
                    $display("FAIL cycle_cmp t=%0t cyc=%0d got=%h expected=%h",
                             $time, cyc, got, expv);
                end
                if (done) done_seen++;
            end
        end
    end

    // ---------------- narrow instances (CNT_W=4) ----------------
    logic       st1 = 1'b0, st20 = 1'b0;
    logic       busy1, done1, pass1, s1a, s2a, ra, o1;
    logic       busy20, done20, pass20, s1b, s2b, rb, o20;
    logic [3:0] err1, first1, err20, first20;
    logic       d1a = 1'b0, d1b = 1'b0;
    always @(posedge clk) begin
        d1a <= s1a;
        d1b <= s1b;
    end
    assign o1  = ~(d1a ^ s2a ^ ra);
    assign o20 = ~(d1b ^ s2b ^ rb);

    example_stim_checker #(.N_VECTORS(1), .CNT_W(4)) u_n1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (st1),
        .busy_o     (busy1),
        .done_o     (done1),
        .pass_o     (pass1),
        .s1_o       (s1a),
        .s2_o       (s2a),
        .r_o        (ra),
        .o_i        (o1),
        .err_cnt_o  (err1),
        .first_err_o(first1)
    );

    example_stim_checker #(.N_VECTORS(20), .CNT_W(4)) u_n20 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (st20),
        .busy_o     (busy20),
        .done_o     (done20),
        .pass_o     (pass20),
        .s1_o       (s1b),
        .s2_o       (s2b),
        .r_o        (rb),
        .o_i        (o20),
        .err_cnt_o  (err20),
        .first_err_o(first20)
    );

    // ---------------- directed sequence ----------------
    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Start a main run and return the number of edges from the start cycle to done_o.
    task automatic run(input int m, input bit pulses, output int lat);
        mode = m;
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            start = pulses && (lat == 50 || lat == N + 2);
            if (done) break;
        end
        start = 1'b0;
        check("run_done", int'(done), 1);
        @(negedge clk);
    endtask

    int lat;
    int ds;
    int guard;

    initial begin
        // Reset state and model pinning.
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({busy, done, pass, s1, s2, r, err, first}), 0);
        check("vec0", int'(vec[0]), 5);
        check("vec1", int'(vec[1]), 2);
        check("vec2", int'(vec[2]), 5);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: clean loopback.
        run(0, 1'b0, lat);
        check("t1_latency", lat, N + 3);
        check("t1_latency_lit", lat, 259);
        check("t1_err", int'(err), 0);
        check("t1_pass", int'(pass), 1);

        // 2: inverted output.
        run(1, 1'b0, lat);
        check("t2_err", int'(err), 256);
        check("t2_first", int'(first), 0);
        check("t2_pass", int'(pass), 0);

        // 3: single flip at vector 17.
        run(2, 1'b0, lat);
        check("t3_err", int'(err), 1);
        check("t3_first", int'(first), 17);
        check("t3_pass", int'(pass), 0);

        // 4: start pulses in RUN and FLUSH are ignored.
        ds = done_seen;
        run(0, 1'b1, lat);
        repeat (3) @(negedge clk);
        check("t4_latency", lat, 259);
        check("t4_done_pulses", done_seen - ds, 1);
        check("t4_pass", int'(pass), 1);

        // 5: reset at vector 100 abandons the run.
        ds = done_seen;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (cyc != 101 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("t5_reached_v100", cyc, 101);
        #2 rst_n = 1'b0;
        #1 check("t5_reset_outputs", int'({busy, done, pass, s1, s2, r, err, first}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_no_done", done_seen - ds, 0);
        run(0, 1'b0, lat);
        check("t5_restart_err", int'(err), 0);
        check("t5_restart_pass", int'(pass), 1);

        // 6a: single vector, wrong output.
        @(negedge clk);
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        guard = 0;
        while (!done1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("t6a_done", int'(done1), 1);
        check("t6a_err", int'(err1), 1);
        check("t6a_first", int'(first1), 0);
        @(negedge clk);
        check("t6a_pass", int'(pass1), 0);
        check("t6a_busy", int'(busy1), 0);

        // 6b: 20 inverted vectors saturate a 4-bit counter.
        st20 = 1'b1;
        @(negedge clk);
        st20 = 1'b0;
        guard = 0;
        while (!done20 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("t6b_done", int'(done20), 1);
        check("t6b_err", int'(err20), 15);
        check("t6b_first", int'(first20), 0);
        @(negedge clk);
        check("t6b_pass", int'(pass20), 0);
        check("t6b_busy", int'(busy20), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
